// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a show-ahead FIFO in fixed bursts onto a
// valid/ready stream via a 2-entry skid buffer; timeout/flush drain leftovers.
// Ports: clk, rst_n, fifo_{empty,almost_empty,rdata}_i, fifo_rden_o,
//        flush_i, m_{valid,data,last}_o, m_ready_i, busy_o.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_almost_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rden_o,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  state_t                state;
  logic [BW-1:0]         beat_cnt;
  logic [WW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] d0;
  logic [DATA_WIDTH-1:0] d1;
  logic                  l0;
  logic                  l1;
  logic [1:0]            cnt;

  logic space;
  logic pop;
  logic push_last;
  logic drain_stop;
  logic slot0;

  // space comes from the registered count only, so m_ready_i never
  // reaches fifo_rden_o combinationally.
  assign space      = (cnt != 2'd2);
  assign pop        = m_valid_o & m_ready_i;
  assign drain_stop = fifo_empty_i |
                      (!fifo_almost_empty_i & !flush_i);
  // Push lands in entry 0 if the buffer is (or becomes) empty this cycle.
  assign slot0      = (cnt == 2'd0) | ((cnt == 2'd1) & pop);

  always_comb begin
    fifo_rden_o = 1'b0;
    push_last   = 1'b1;
    case (state)
      BURST: begin
        fifo_rden_o = space & !fifo_empty_i;
        push_last   = (beat_cnt == BEAT_MAX);
      end
      DRAIN: begin
        fifo_rden_o = space & !drain_stop;
      end
      default: begin
        fifo_rden_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        IDLE: begin
          if (!fifo_almost_empty_i) begin
            state    <= BURST;
            beat_cnt <= '0;
          end else if (!fifo_empty_i &&
                       (wait_cnt == WAIT_MAX || flush_i)) begin
            state <= DRAIN;
          end else if (!fifo_empty_i) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        BURST: begin
          if (fifo_rden_o) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_MAX) state <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_stop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      if (fifo_rden_o) begin
        if (slot0) begin
          d0 <= fifo_rdata_i;
          l0 <= push_last;
        end else begin
          d1 <= fifo_rdata_i;
          l1 <= push_last;
        end
      end
      cnt <= cnt + {1'b0, fifo_rden_o} - {1'b0, pop};
    end
  end

  assign m_valid_o = (cnt != 2'd0);
  assign m_data_o  = d0;
  assign m_last_o  = l0;
  assign busy_o    = (state != IDLE) | (cnt != 2'd0);

endmodule
